inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 fetch_en  in  1  high = fetching permitted.
REQ-004 redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
REQ-005 redirect_pc  in  8  new fetch address.
REQ-006 imem_req  out  1  instruction memory request.
REQ-007 imem_addr  out  8  request address.
REQ-008 imem_ack  in  1  request accepted; imem_rdata valid this cycle.
REQ-009 imem_rdata  in  24  instruction word.
REQ-010 inst_valid  out  1  head instruction available to decode.
REQ-011 inst_ready  in  1  decode consumes head when high with inst_valid.
REQ-012 inst_word  out  24  head instruction word.
REQ-013 opcode  out  6  inst_word[23:18], the field fed to the control unit.
REQ-014 inst_pc  out  8  address of head instruction.

Function
REQ-015 FSM states IDLE (no request), REQ (request outstanding), DROP (outstanding request whose data is discarded).
REQ-016 Memory handshake: imem_req and imem_addr held stable from assertion until the imem_ack cycle; at most one request outstanding.
REQ-017 IDLE->REQ when fetch_en=1 and registered buffer count<2; imem_addr=pc.
REQ-018 On imem_ack in REQ: push {pc, imem_rdata}; pc<=pc+1 (mod 256, 255 wraps to 0); stay REQ if fetch_en=1 and post-push count<2, else IDLE.
REQ-019 fetch_en deasserted in REQ: outstanding request completes and its data is pushed, then IDLE.
REQ-020 Buffer: 2-entry FIFO of {pc, word}; no request issued while count=2, so overflow is impossible.
REQ-021 Pop when inst_valid and inst_ready; push and pop in the same cycle leave count unchanged; pop from an empty buffer is ignored.
REQ-022 inst_valid = (count!=0); inst_word/inst_pc/opcode show the head; when empty, inst_word=0, inst_pc=0, opcode=6'b000000 (NOP).
REQ-023 Head outputs remain stable while inst_valid=1 and inst_ready=0.
REQ-024 Redirect has priority over all other events: FIFO flushed (count=0, no pop recorded), pc<=redirect_pc.
REQ-025 Redirect in REQ without ack: go to DROP, request held until ack, data discarded, then REQ/IDLE per REQ-017 from redirect_pc.
REQ-026 Redirect in the same cycle as imem_ack: data discarded, no push; next state per REQ-017 with pc=redirect_pc.
REQ-027 Redirect in DROP: pc updated again, stay DROP.
REQ-028 Latency: first inst_valid one cycle after the imem_ack cycle; back-to-back acks sustain one instruction per cycle.

Reset
REQ-029 rst_n low: state=IDLE, pc=0, FIFO empty, imem_req=0, imem_addr=0, inst_valid=0, inst_word=0, inst_pc=0, opcode=0, asynchronously.
REQ-030 Reset mid-request discards the outstanding request; first fetch after release is from address 0.

Structure
REQ-031 Shared package eye_pkg holds OPCODE_W=6, INST_W=24, PC_W=8, OPCODE_LSB=18, OP_NOP=6'b000000, and the fetch state enum.
REQ-032 The 2-entry FIFO is one sub-module, inst_fifo, parameterised by data width; all other logic lives in inst_fetch.

Verification
REQ-033 Reset release, fetch_en=1, imem_ack returned the cycle after each request, inst_ready=1 -> addresses 0,1,2,... issued; inst_pc sequence matches and opcode = rdata[23:18].
REQ-034 inst_ready=0, fetch_en=1 -> exactly 2 instructions buffered, imem_req low afterwards; inst_ready=1 -> fetch resumes at address 2.
REQ-035 Redirect to 0x40 while a request to 0x05 is unacked; ack after 3 cycles -> 0x05 data never valid; next imem_addr=0x40.
REQ-036 Redirect to 0x10 in the same cycle as imem_ack -> no push, FIFO empty, next request to 0x10.
REQ-037 pc=0xFF fetched and acked -> next imem_addr=0x00; inst_pc of head=0xFF.
REQ-038 rst_n asserted mid-request with 1 buffered entry -> all outputs 0 immediately; after release, first request to 0x00.

Source files
------------

// File: rtl/eye_pkg.sv
// Shared widths, opcode field position and fetch FSM state type
// for the instruction fetch unit.
package eye_pkg;

    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned INST_W     = 24;
    localparam int unsigned PC_W       = 8;
    localparam int unsigned OPCODE_LSB = 18;
    localparam int unsigned ENTRY_W    = PC_W + INST_W;

    localparam logic [OPCODE_W-1:0] OP_NOP = 6'b000000;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/inst_fifo.sv
// Two-entry FIFO with synchronous flush; flush beats push/pop,
// and a pop from an empty FIFO is ignored.
module inst_fifo #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != 2'd0);
        // Full FIFO only takes a push if the head leaves in the same cycle
        do_push  = push_i && ((count_q != 2'd2) || do_pop);

        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// two-entry {pc, word} buffer, with redirect flush and drop of stale data.
module inst_fetch
    import eye_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_en,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INST_W-1:0]   imem_rdata,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_W-1:0]   inst_word,
    output logic [OPCODE_W-1:0] opcode,
    output logic [PC_W-1:0]     inst_pc
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic [PC_W-1:0]    pc_inc;
    logic [2:0]         post_cnt;
    logic               push, pop;
    logic [1:0]         count;
    logic [ENTRY_W-1:0] head;
    logic [INST_W-1:0]  head_word;

    assign pop = inst_valid && inst_ready && !redirect;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        push     = 1'b0;
        pc_inc   = pc_q + PC_W'(1);
        post_cnt = {1'b0, count} + 3'd1 - {2'b00, pop};

        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (fetch_en) begin
                        state_d = StReq;
                        addr_d  = redirect_pc;
                    end
                end else if (fetch_en && (count < 2'd2)) begin
                    state_d = StReq;
                    addr_d  = pc_q;
                end
            end
            StReq: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (!imem_ack) begin
                        state_d = StDrop;
                    end else if (fetch_en) begin
                        addr_d = redirect_pc;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_inc;
                    if (fetch_en && (post_cnt < 3'd2)) begin
                        addr_d = pc_inc;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDrop: begin
                // addr_q stays on the stale request until its ack arrives
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    if (fetch_en && (redirect || (count < 2'd2))) begin
                        state_d = StReq;
                        addr_d  = pc_d;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    inst_fifo #(
        .Width (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({addr_q, imem_rdata}),
        .rdata_o (head),
        .count_o (count)
    );

    assign imem_req   = (state_q != StIdle);
    assign imem_addr  = imem_req ? addr_q : '0;
    assign inst_valid = (count != 2'd0);
    assign head_word  = head[INST_W-1:0];
    assign inst_word  = inst_valid ? head_word : '0;
    assign inst_pc    = inst_valid ? head[ENTRY_W-1:INST_W] : '0;
    assign opcode     = inst_valid ? head_word[OPCODE_LSB +: OPCODE_W] : OP_NOP;

endmodule
